// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-bus snoop, DMA bus-master and OAM write signals of the sprite DMA
interface oam_dma_if;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  bus_rdata;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    modport master (
        input  cpu_ce, cpu_addr, cpu_wr, cpu_wdata, bus_rdata,
        output cpu_halt, dma_active, dma_addr, dma_rd, oam_addr, oam_wdata, oam_we
    );
    modport slave (
        output cpu_ce, cpu_addr, cpu_wr, cpu_wdata, bus_rdata,
        input  cpu_halt, dma_active, dma_addr, dma_rd, oam_addr, oam_wdata, oam_we
    );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: snoops $4014 writes, halts the CPU and copies one 256-byte page into OAM
module oam_dma #(
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input logic       clk,
    input logic       rst,
    oam_dma_if.master bus
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, GET, PUT} state_e;
    state_e     state_q, state_d;
    logic       phase_q;
    logic [7:0] page_q, page_d, idx_q, idx_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
        end else if (bus.cpu_ce) begin
            state_q <= state_d;
            phase_q <= ~phase_q;
            page_q  <= page_d;
            idx_q   <= idx_d;
        end
    end
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (bus.cpu_wr && bus.cpu_addr == DMA_REG) begin
                state_d = HALT;
                page_d  = bus.cpu_wdata;
                idx_d   = 8'h00;
            end
            // phase 0 now means the next cycle is a put slot, so burn one more cycle
            HALT:  state_d = phase_q ? GET : ALIGN;
            ALIGN: state_d = GET;
            GET:   state_d = PUT;
            PUT: begin
                state_d = (idx_q == 8'hFF) ? IDLE : GET;
                idx_d   = idx_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.cpu_halt   = state_q != IDLE;
    assign bus.dma_active = state_q != IDLE;
    assign bus.dma_rd     = state_q == GET;
    assign bus.dma_addr   = (state_q == GET) ? {page_q, idx_q} : 16'h0000;
    assign bus.oam_we     = (state_q == PUT) && bus.cpu_ce;
    assign bus.oam_addr   = (state_q == PUT) ? idx_q : 8'h00;
    assign bus.oam_wdata  = (state_q == PUT) ? bus.bus_rdata : 8'h00;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: decode table plus scoreboarded full-page transfers for oam_dma
module tb_oam_dma;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oam_dma_if bus();
    oam_dma #(.DMA_REG(16'h4014)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] ram [2048];
    logic [7:0] oam [256];
    // registered RAM: output register loads only on DMA read cycles
    always @(posedge clk) if (bus.dma_rd) bus.bus_rdata <= ram[bus.dma_addr[10:0]];
    always @(posedge clk) if (bus.oam_we) oam[bus.oam_addr] <= bus.oam_wdata;

    typedef struct {
        logic        rst;
        logic        ce;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic        exp;
    } vec_t;
    vec_t tv [7];

    int n_vec = 0, n_bad = 0;
    int div = 1, ce_cnt = 0;
    int halt_cnt = 0, we_cnt = 0, first_get = -1;
    logic ph_m = 1'b0;
    logic [15:0] sbq [$];

    function automatic logic [7:0] pat(input logic [7:0] pg, input logic [7:0] i);
        case (pg[2:0])
            3'd2:    pat = i ^ 8'hA5;
            3'd3:    pat = i ^ 8'h3C;
            3'd7:    pat = ~i + 8'd7;
            default: pat = {pg[2:0], 5'd0} ^ i;
        endcase
    endfunction

    function automatic logic [35:0] outs();
        outs = {bus.cpu_halt, bus.dma_active, bus.dma_rd, bus.oam_we,
                bus.dma_addr, bus.oam_addr, bus.oam_wdata};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sample();
        logic [15:0] e;
        if (bus.cpu_ce && bus.cpu_halt) begin
            if (bus.dma_rd && first_get < 0) first_get = halt_cnt;
            halt_cnt++;
        end
        if (bus.oam_we) begin
            we_cnt++;
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL oam_write_extra: got addr %0h data %0h expected no write",
                         bus.oam_addr, bus.oam_wdata);
            end else begin
                e = sbq.pop_front();
                chk("oam_write", {bus.cpu_ce, bus.oam_addr, bus.oam_wdata}, {1'b1, e});
            end
        end
    endtask

    task automatic tick(input logic ce);
        bus.cpu_ce = ce;
        @(negedge clk);
        sample();
        @(posedge clk);
        ph_m = rst ? 1'b0 : (ce ? ~ph_m : ph_m);
        #1;
    endtask

    function automatic logic nce();
        nce = ((ce_cnt + 1) % div) == 0;
    endfunction

    task automatic step();
        ce_cnt = (ce_cnt + 1) % div;
        tick(ce_cnt == 0);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int want);
        for (int k = 0; k < 8 && !(nce() && (want < 0 || int'(ph_m) == want)); k++) step();
        bus.cpu_addr  = a;
        bus.cpu_wr    = 1'b1;
        bus.cpu_wdata = d;
        step();
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wdata = 8'h00;
    endtask

    task automatic start_xfer(input logic [7:0] pg, input int want);
        halt_cnt  = 0;
        we_cnt    = 0;
        first_get = -1;
        for (int i = 0; i < 256; i++) sbq.push_back({8'(i), pat(pg, 8'(i))});
        cpu_write(16'h4014, pg, want);
        chk("halt_rise", bus.cpu_halt, 1);
    endtask

    task automatic finish_xfer(input logic [7:0] pg, input int want);
        int bad;
        for (int k = 0; k < 6000 && bus.cpu_halt; k++) step();
        chk("done_timeout", bus.cpu_halt, 0);
        chk("stall_len", halt_cnt, want ? 514 : 513);
        chk("first_get", first_get, want ? 2 : 1);
        chk("oam_we_count", we_cnt, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (oam[i] !== pat(pg, 8'(i))) bad++;
        chk("oam_content", bad, 0);
        chk("idle_outputs", outs(), 0);
    endtask

    initial begin
        int bad;
        logic [10:0] av;
        for (int a = 0; a < 2048; a++) begin
            av = 11'(a);
            ram[a] = pat({5'd0, av[10:8]}, av[7:0]);
        end
        tv[0] = '{1'b0, 1'b1, 1'b1, 16'h4013, 8'h02, 1'b0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 16'h4014, 8'h02, 1'b0};
        tv[2] = '{1'b0, 1'b0, 1'b1, 16'h4014, 8'h02, 1'b0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 16'h4015, 8'h02, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b1, 16'h0014, 8'h02, 1'b0};
        tv[5] = '{1'b1, 1'b1, 1'b1, 16'h4014, 8'h02, 1'b0};
        tv[6] = '{1'b0, 1'b1, 1'b1, 16'h4014, 8'h02, 1'b1};
        bus.cpu_ce    = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_wr    = 1'b0;
        bus.cpu_wdata = 8'h00;
        rst = 1'b1;
        tick(1'b1);
        tick(1'b1);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        tick(1'b1);

        for (int i = 0; i < 7; i++) begin
            rst           = tv[i].rst;
            bus.cpu_wr    = tv[i].wr;
            bus.cpu_addr  = tv[i].a;
            bus.cpu_wdata = tv[i].d;
            tick(tv[i].ce);
            rst        = 1'b0;
            bus.cpu_wr = 1'b0;
            bus.cpu_addr = 16'h0000;
            chk($sformatf("decode[%0d]", i), {bus.cpu_halt, bus.dma_active, bus.dma_rd},
                {tv[i].exp, tv[i].exp, 1'b0});
            rst = 1'b1;
            tick(1'b1);
            rst = 1'b0;
        end

        start_xfer(8'h02, 0);
        finish_xfer(8'h02, 0);
        start_xfer(8'h02, 1);
        finish_xfer(8'h02, 1);

        start_xfer(8'h02, 0);
        for (int k = 0; k < 3000 && we_cnt < 50; k++) step();
        cpu_write(16'h4014, 8'h05, -1);
        cpu_write(16'h4013, 8'h06, -1);
        bus.cpu_addr = 16'h4014;
        step();
        bus.cpu_addr = 16'h0000;
        finish_xfer(8'h02, 0);

        start_xfer(8'h03, -1);
        for (int k = 0; k < 3000 && we_cnt < 100; k++) step();
        chk("partial_count", we_cnt, 100);
        rst = 1'b1;
        tick(1'b1);
        chk("rst_mid_outputs", outs(), 0);
        sbq.delete();
        tick(1'b1);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (oam[i] !== (i < 100 ? pat(8'h03, 8'(i)) : pat(8'h02, 8'(i)))) bad++;
        chk("oam_partial", bad, 0);
        start_xfer(8'h03, 1);
        finish_xfer(8'h03, 1);

        div    = 3;
        ce_cnt = 0;
        start_xfer(8'h07, 0);
        finish_xfer(8'h07, 0);
        div = 1;
        tick(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite DMA engine for the CPU side of the NES. It snoops CPU writes to $4014, halts the 6502, and copies one 256-byte CPU page into PPU OAM. Each byte is read over the CPU bus, normally from the 2 KB work RAM, and written to OAM.

The block sits between the CPU core and the CPU bus mux. While `dma_active` is high, `dma_addr`/`dma_rd` drive the bus in place of the CPU, and the registered RAM output returns on `bus_rdata`.

## Interface
Parameters:
- `DMA_REG`, 16'h4014, CPU address that triggers a transfer

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cpu_ce`  in  1  CPU cycle enable; all state advances only on clocks with `cpu_ce`=1
- `cpu_addr`  in  16  CPU bus address
- `cpu_wr`  in  1  CPU write strobe
- `cpu_wdata`  in  8  CPU write data (page number)
- `bus_rdata`  in  8  bus read data; registered, valid one `clk` after the address
- `cpu_halt`  out  1  stall request to CPU (RDY low)
- `dma_active`  out  1  bus mux select: DMA owns the CPU bus
- `dma_addr`  out  16  bus address during DMA reads
- `dma_rd`  out  1  DMA read cycle; bus write_enable must be 0 while high
- `oam_addr`  out  8  OAM byte index 0..255; the PPU adds its own OAMADDR offset
- `oam_wdata`  out  8  byte to OAM
- `oam_we`  out  1  OAM write strobe, one `clk` wide

## Operation
- Free-running `phase` flop toggles on every `cpu_ce`; reset value 0.
  - `phase`=0 marks a get cycle, `phase`=1 a put cycle.
- Registers:
  - `page` (8 bits)
  - `idx` (8 bits)
  - `state` ∈ {IDLE, HALT, ALIGN, GET, PUT}
- IDLE:
  - Trigger: `cpu_ce`, `cpu_wr` and `cpu_addr`==`DMA_REG`.
  - On trigger: latch `page`=`cpu_wdata`, `idx`=0, go to HALT.
  - CPU reads of `DMA_REG` do not trigger.
- HALT: one dummy cycle.
  - Next state is ALIGN if the following cycle is a put cycle (`phase`=0 now).
  - Otherwise next state is GET.
- ALIGN: one dummy cycle, then GET.
- GET:
  - `dma_addr`={`page`,`idx`}, `dma_rd`=1.
  - Next state PUT.
- PUT:
  - `oam_we`=`cpu_ce`, `oam_addr`=`idx`, `oam_wdata`=`bus_rdata`.
  - On `cpu_ce`, if `idx`==255 go to IDLE; else increment `idx` and go to GET.
- Decoded outputs:
  - `cpu_halt`=`dma_active`=(`state`≠IDLE).
  - `dma_addr`=0 and `dma_rd`=0 outside GET.
  - `oam_we`=0 and `oam_wdata`=0 outside PUT.
- Triggers while not IDLE are ignored; `page` is not reloaded.
- `dma_addr` is passed unchanged; mirroring of RAM into 11 bits is the decoder's job.
  - Example: page $08 reads $0800-$08FF, which maps to RAM $000-$0FF.
- `idx` wraps only at completion; no partial-page transfers.

## Timing
- Reset values:
  - `cpu_halt`, `dma_active`, `dma_rd`, `oam_we` = 0.
  - `dma_addr`=0, `oam_addr`=0, `oam_wdata`=0.
  - `state`=IDLE, `phase`=0, `idx`=0, `page`=0.
- Trigger write on CPU cycle N: `cpu_halt` rises at cycle N+1 (HALT state).
- Stall length, counted in `cpu_ce` cycles:
  - 513 cycles if cycle N+2 is a get cycle.
  - 514 cycles if cycle N+2 is a put cycle (ALIGN inserted).
- Read latency: `bus_rdata` sampled in PUT must equal the RAM content at the GET address.
  - This holds because the GET→PUT transition is ≥1 `clk` later.
  - With sparse `cpu_ce`, `dma_addr` holds through the whole GET cycle.
- Final PUT (`idx`=255): `cpu_halt` deasserts on the next cycle, and the CPU resumes there.
- `rst` mid-transfer takes effect the next `clk`:
  - All outputs return to 0 and the transfer is abandoned.
  - OAM keeps its partial contents.
- Trigger coincident with `rst`: `rst` wins, no transfer.

## Test plan
- Even-aligned transfer:
  - Stimulus: RAM $200+i = i^8'hA5; write $02 to $4014 so cycle N+2 is a get cycle.
  - Required: `cpu_halt` high exactly 513 `cpu_ce` cycles; 256 `oam_we` pulses; OAM[i]=i^8'hA5, in order 0..255.
- Odd-aligned transfer: same stimulus shifted one cycle.
  - Required: 514 halted cycles.
  - Required: the first GET occurs one cycle later than in the even case.
  - Required: identical OAM contents.
- Non-trigger accesses: write to $4013, read of $4014, and a write to $4014 during an active transfer.
  - Required: none starts or restarts a transfer.
  - Required: the active transfer's `page` is unchanged.
- Reset mid-transfer: assert `rst` after 100 OAM writes.
  - Required: next `clk` all outputs 0 and `state` IDLE.
  - Required: a new $4014 write of $03 then performs a full 513/514-cycle copy.
- Sparse enable: `cpu_ce` every 3rd `clk`, page $07.
  - Required: correct data from $0700-$07FF.
  - Required: `oam_we` pulses only on `cpu_ce` clocks.
  - Required: stall length of 513/514 counted in `cpu_ce` cycles.
